// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV instruction fetch slice.
// Holds the fetch FSM encoding, the default boot address and the control-flow opcodes.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Without compressed instructions every target must be word aligned; bit0 is
    // already cleared for JALR and is zero for pre-shifted B/J immediates.
    function automatic logic target_misaligned(input logic [31:0] target);
        return target[1];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction currently held at decode.
// Priority is jalr > jal > branch_taken > sequential; all sums wrap modulo 2^32.
module next_pc_calc
    import rv_fetch_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic [31:0] instr_pc_plus4,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        jalr,
    input  logic        jal,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jalr_sum;
    logic [31:0] rel_target;

    assign jalr_sum   = rs1_data + imm;
    assign rel_target = instr_pc + imm;

    always_comb begin
        next_pc = instr_pc_plus4;
        if (jalr) begin
            next_pc = {jalr_sum[31:1], 1'b0};
        end else if (jal || branch_taken) begin
            next_pc = rel_target;
        end
    end

    assign misaligned = target_misaligned(next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request a word, hold it for decode,
// then redirect or advance; a misaligned redirect target halts until reset.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        decode_ready,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        misalign_err
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_pc_reg, instr_pc_plus4_reg;
    logic         misalign_err_reg, misalign_err_next;
    logic         capture;
    logic         handshake;
    logic [31:0]  next_pc;
    logic         next_pc_misaligned;

    next_pc_calc u_next_pc_calc (
        .instr_pc       (instr_pc_reg),
        .instr_pc_plus4 (instr_pc_plus4_reg),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .jalr           (jalr),
        .jal            (jal),
        .branch_taken   (branch_taken),
        .next_pc        (next_pc),
        .misaligned     (next_pc_misaligned)
    );

    assign handshake = (state_reg == HOLD) && decode_ready;

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        capture           = 1'b0;
        misalign_err_next = 1'b0;
        case (state_reg)
            FETCH: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // Redirect controls only matter on the accepting cycle.
                if (handshake) begin
                    if (next_pc_misaligned) begin
                        misalign_err_next = 1'b1;
                        state_next        = HALT;
                    end else begin
                        pc_next    = next_pc;
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= FETCH;
            pc_reg             <= RESET_PC;
            instr_reg          <= 32'h0;
            instr_pc_reg       <= 32'h0;
            instr_pc_plus4_reg <= 32'h0;
            misalign_err_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            misalign_err_reg <= misalign_err_next;
            if (capture) begin
                instr_reg          <= imem_rdata;
                instr_pc_reg       <= pc_reg;
                instr_pc_plus4_reg <= pc_reg + 32'd4;
            end
        end
    end

    // Gating with reset keeps the request low for the whole reset pulse.
    assign imem_req       = (state_reg == FETCH) && !reset;
    assign imem_addr      = pc_reg;
    assign instr_valid    = (state_reg == HOLD);
    assign instr          = instr_reg;
    assign instr_pc       = instr_pc_reg;
    assign instr_pc_plus4 = instr_pc_plus4_reg;
    assign misalign_err   = misalign_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential flow, branches, jumps, stall,
// address wrap, misaligned halt and reset during an outstanding fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        decode_ready;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        misalign_err;

    int checks_count = 0;
    int fail_count   = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .decode_ready   (decode_ready),
        .branch_taken   (branch_taken),
        .jal            (jal),
        .jalr           (jalr),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns one negedge later in HOLD.
    task automatic fetch_cycle(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        check_eq({tag, "_addr"}, imem_addr, exp_addr);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        check_eq({tag, "_instr"}, instr, data);
        check_eq({tag, "_pc"}, instr_pc, exp_addr);
        check_eq({tag, "_pc4"}, instr_pc_plus4, exp_addr + 32'd4);
        check_eq({tag, "_req_hold"}, {31'b0, imem_req}, 32'd0);
        $display("fetch %s addr=0x%08h instr=0x%08h pc4=0x%08h", tag, imem_addr, instr, instr_pc_plus4);
    endtask

    // One accepting cycle at decode with the given redirect controls.
    task automatic accept(input logic j_r, input logic j, input logic br,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v);
        decode_ready = 1'b1;
        jalr         = j_r;
        jal          = j;
        branch_taken = br;
        imm          = imm_v;
        rs1_data     = rs1_v;
        @(negedge clk);
        decode_ready = 1'b0;
        jalr         = 1'b0;
        jal          = 1'b0;
        branch_taken = 1'b0;
        imm          = 32'h0;
        rs1_data     = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", instr_pc, 32'h0);
        check_eq("rst_pc4", instr_pc_plus4, 32'h0);
        check_eq("rst_err", {31'b0, misalign_err}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_rel_req", {31'b0, imem_req}, 32'd1);
        check_eq("rst_rel_addr", imem_addr, 32'h0);
        $display("reset released");
    endtask

    initial begin
        reset        = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        decode_ready = 1'b0;
        branch_taken = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        imm          = 32'h0;
        rs1_data     = 32'h0;

        do_reset();

        // Sequential flow
        fetch_cycle("seq0", 32'h0, 32'h0000_0013);
        accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_cycle("seq1", 32'h4, 32'h0010_0093);
        accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_cycle("seq2", 32'h8, 32'h0020_0113);

        // Branch taken / not taken from 0x100 with a negative offset
        accept(1'b0, 1'b1, 1'b0, 32'h0000_00F8, 32'h0);
        fetch_cycle("to100", 32'h100, 32'hFE00_08E3);
        accept(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
        fetch_cycle("br_tk", 32'h0F0, 32'h0100_006F);
        accept(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        fetch_cycle("back100", 32'h100, 32'hFE00_08E3);
        accept(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        fetch_cycle("br_nt", 32'h104, 32'h0040_8067);

        // JALR wins over JAL; bit0 of the sum is cleared
        accept(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_2001);
        fetch_cycle("jalr", 32'h2004, 32'h0000_0067);
        accept(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0010);
        fetch_cycle("to10", 32'h10, 32'h0000_006F);
        accept(1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
        fetch_cycle("jal", 32'h810, 32'h1234_5678);

        // Stall with toggling redirects and a stray rvalid
        for (int i = 0; i < 3; i++) begin
            decode_ready = 1'b0;
            branch_taken = (i % 2 == 0);
            imm          = 32'h40;
            imem_rvalid  = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
            @(negedge clk);
            check_eq("stall_instr", instr, 32'h1234_5678);
            check_eq("stall_pc", instr_pc, 32'h810);
            check_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
            $display("stall cycle %0d instr=0x%08h", i, instr);
        end
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        branch_taken = 1'b0;
        accept(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        fetch_cycle("after_stall", 32'h814, 32'h0000_0013);

        // Wrap from the top of the address space
        accept(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        fetch_cycle("top", 32'hFFFF_FFFC, 32'h0000_0013);
        check_eq("wrap_pc4", instr_pc_plus4, 32'h0);
        accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("wrap_err", {31'b0, misalign_err}, 32'd0);
        fetch_cycle("wrap", 32'h0, 32'h0060_006F);

        // Misaligned JAL target halts the unit
        accept(1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
        check_eq("mis_err", {31'b0, misalign_err}, 32'd1);
        check_eq("mis_req", {31'b0, imem_req}, 32'd0);
        check_eq("mis_valid", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        decode_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("halt_err", {31'b0, misalign_err}, 32'd0);
            check_eq("halt_req", {31'b0, imem_req}, 32'd0);
            check_eq("halt_valid", {31'b0, instr_valid}, 32'd0);
            $display("halt cycle %0d", i);
        end
        imem_rvalid  = 1'b0;
        decode_ready = 1'b0;

        // Reset during an outstanding fetch at 0x40 with coincident rvalid
        do_reset();
        fetch_cycle("pre40", 32'h0, 32'h0400_006F);
        accept(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        check_eq("out40_addr", imem_addr, 32'h40);
        check_eq("out40_req", {31'b0, imem_req}, 32'd1);
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        #1;
        check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        check_eq("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("mid_rst_instr", instr, 32'h0);
        check_eq("mid_rst_addr", imem_addr, 32'h0);
        check_eq("mid_rst_req1", {31'b0, imem_req}, 32'd1);
        $display("reset mid-fetch addr=0x%08h", imem_addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks_count, fail_count);
        $finish;
    end

endmodule
